// File: rtl/fetch_unit.sv
// MIPS instruction-fetch stage: owns the PC, issues one word-aligned request at a time,
// and presents instruction plus PC+4 to IF/ID with stall hold and redirect flush.
module fetch_unit #(
   parameter logic [31:0] PC_RESET = 32'h0000_0000,
   parameter logic [31:0] NOP      = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        stall,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic [31:0] instr_out,
   output logic [31:0] pc4_out,
   output logic        valid_out
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_HOLD = 2'd2,
      S_DROP = 2'd3
   } state_e;

   state_e      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic        req_q, req_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] instr_q, instr_d;
   logic [31:0] pc4_q, pc4_d;
   logic        valid_q, valid_d;

   logic [31:0] target;
   logic [31:0] pc_plus4;
   logic        ack;

   assign target   = {redirect_pc[31:2], 2'b00};
   assign pc_plus4 = pc_q + 32'd4;
   // A response is only meaningful while our own request is on the bus.
   assign ack      = imem_ack & req_q;

   always_comb begin
      // NOTE: every _d gets a hold default first so no path leaves it unassigned (no latches).
      state_d = state_q;
      pc_d    = pc_q;
      req_d   = req_q;
      addr_d  = addr_q;
      instr_d = instr_q;
      pc4_d   = pc4_q;
      valid_d = valid_q;

      if (redirect) begin
         pc_d    = target;
         valid_d = 1'b0;
         instr_d = NOP;
         unique case (state_q)
            S_IDLE, S_HOLD: begin
               state_d = S_WAIT;
               req_d   = 1'b1;
               addr_d  = target;
            end
            S_WAIT, S_DROP: begin
               // The old request must complete before a new address may be issued.
               if (ack) begin
                  state_d = S_WAIT;
                  addr_d  = target;
               end else begin
                  state_d = S_DROP;
               end
            end
            default: state_d = S_IDLE;
         endcase
      end else begin
         unique case (state_q)
            S_IDLE: begin
               state_d = S_WAIT;
               req_d   = 1'b1;
               addr_d  = pc_q;
            end
            S_WAIT: begin
               if (ack) begin
                  state_d = S_HOLD;
                  instr_d = imem_rdata;
                  pc4_d   = pc_plus4;
                  pc_d    = pc_plus4;
                  valid_d = 1'b1;
                  req_d   = 1'b0;
               end
            end
            S_HOLD: begin
               if (!stall) begin
                  state_d = S_WAIT;
                  valid_d = 1'b0;
                  req_d   = 1'b1;
                  addr_d  = pc_q;
               end
            end
            S_DROP: begin
               if (ack) begin
                  state_d = S_WAIT;
                  addr_d  = pc_q;
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      if (!rst_n) begin
         state_q <= S_IDLE;
         pc_q    <= PC_RESET;
         req_q   <= 1'b0;
         addr_q  <= PC_RESET;
         instr_q <= NOP;
         pc4_q   <= 32'd0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         req_q   <= req_d;
         addr_q  <= addr_d;
         instr_q <= instr_d;
         pc4_q   <= pc4_d;
         valid_q <= valid_d;
      end
   end

   assign imem_req  = req_q;
   assign imem_addr = addr_q;
   assign instr_out = instr_q;
   assign pc4_out   = pc4_q;
   assign valid_out = valid_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed testbench for fetch_unit: reset, fetch, stall, redirect/drop, PC wrap and reset abort.
module tb_fetch_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        stall;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        imem_ack;
   logic [31:0] imem_rdata;

   logic        req_a, valid_a;
   logic [31:0] addr_a, instr_a, pc4_a;
   logic        req_b, valid_b;
   logic [31:0] addr_b, instr_b, pc4_b;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   fetch_unit dut (
      .clk(clk), .rst_n(rst_n), .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
      .imem_req(req_a), .imem_addr(addr_a), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
      .instr_out(instr_a), .pc4_out(pc4_a), .valid_out(valid_a)
   );

   fetch_unit #(.PC_RESET(32'hFFFF_FFFC)) dut_wrap (
      .clk(clk), .rst_n(rst_n), .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
      .imem_req(req_b), .imem_addr(addr_b), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
      .instr_out(instr_b), .pc4_out(pc4_b), .valid_out(valid_b)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = '0; imem_ack = 1'b0; imem_rdata = '0;
      repeat (3) tick();
      n_checks++; if (req_a !== 1'b0) begin n_fail++; $display("FAIL reset_req got=%b exp=0", req_a); end
      n_checks++; if (valid_a !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", valid_a); end
      n_checks++; if (addr_a !== 32'h0) begin n_fail++; $display("FAIL reset_addr got=%h exp=0", addr_a); end
      n_checks++; if (pc4_a !== 32'h0) begin n_fail++; $display("FAIL reset_pc4 got=%h exp=0", pc4_a); end
      rst_n = 1'b1;
      n_checks++; if (req_a !== 1'b0) begin n_fail++; $display("FAIL idle_req got=%b exp=0", req_a); end
      tick();
      n_checks++; if (req_a !== 1'b1) begin n_fail++; $display("FAIL first_req got=%b exp=1", req_a); end
      n_checks++; if (addr_a !== 32'h0) begin n_fail++; $display("FAIL first_addr got=%h exp=0", addr_a); end
      n_checks++; if (valid_a !== 1'b0) begin n_fail++; $display("FAIL first_valid got=%b exp=0", valid_a); end
      n_checks++; if (instr_a !== 32'h0) begin n_fail++; $display("FAIL first_instr got=%h exp=0", instr_a); end
   endtask

   task automatic test_first_ack();
      imem_ack = 1'b1; imem_rdata = 32'h2001_0005;
      tick();
      imem_ack = 1'b0;
      n_checks++; if (valid_a !== 1'b1) begin n_fail++; $display("FAIL ack_valid got=%b exp=1", valid_a); end
      n_checks++; if (instr_a !== 32'h2001_0005) begin n_fail++; $display("FAIL ack_instr got=%h exp=20010005", instr_a); end
      n_checks++; if (pc4_a !== 32'h4) begin n_fail++; $display("FAIL ack_pc4 got=%h exp=4", pc4_a); end
      n_checks++; if (req_a !== 1'b0) begin n_fail++; $display("FAIL ack_req got=%b exp=0", req_a); end
      tick();
      n_checks++; if (valid_a !== 1'b0) begin n_fail++; $display("FAIL next_valid got=%b exp=0", valid_a); end
      n_checks++; if (req_a !== 1'b1) begin n_fail++; $display("FAIL next_req got=%b exp=1", req_a); end
      n_checks++; if (addr_a !== 32'h4) begin n_fail++; $display("FAIL next_addr got=%h exp=4", addr_a); end
   endtask

   task automatic test_stall();
      imem_ack = 1'b1; imem_rdata = 32'h8C22_0010;
      tick();
      imem_ack = 1'b0; stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         n_checks++; if (instr_a !== 32'h8C22_0010) begin n_fail++; $display("FAIL stall_instr[%0d] got=%h exp=8c220010", i, instr_a); end
         n_checks++; if (pc4_a !== 32'h8) begin n_fail++; $display("FAIL stall_pc4[%0d] got=%h exp=8", i, pc4_a); end
         n_checks++; if (req_a !== 1'b0) begin n_fail++; $display("FAIL stall_req[%0d] got=%b exp=0", i, req_a); end
         n_checks++; if (valid_a !== 1'b1) begin n_fail++; $display("FAIL stall_valid[%0d] got=%b exp=1", i, valid_a); end
      end
      stall = 1'b0;
      tick();
      n_checks++; if (req_a !== 1'b1) begin n_fail++; $display("FAIL unstall_req got=%b exp=1", req_a); end
      n_checks++; if (addr_a !== 32'h8) begin n_fail++; $display("FAIL unstall_addr got=%h exp=8", addr_a); end
   endtask

   task automatic test_redirect_drop();
      redirect = 1'b1; redirect_pc = 32'h0000_0103;
      tick();
      redirect = 1'b0;
      n_checks++; if (addr_a !== 32'h8) begin n_fail++; $display("FAIL drop_addr0 got=%h exp=8", addr_a); end
      n_checks++; if (req_a !== 1'b1) begin n_fail++; $display("FAIL drop_req0 got=%b exp=1", req_a); end
      tick();
      n_checks++; if (addr_a !== 32'h8) begin n_fail++; $display("FAIL drop_addr1 got=%h exp=8", addr_a); end
      n_checks++; if (valid_a !== 1'b0) begin n_fail++; $display("FAIL drop_valid1 got=%b exp=0", valid_a); end
      imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
      tick();
      imem_ack = 1'b0;
      n_checks++; if (valid_a !== 1'b0) begin n_fail++; $display("FAIL drop_valid2 got=%b exp=0", valid_a); end
      n_checks++; if (req_a !== 1'b1) begin n_fail++; $display("FAIL drop_req2 got=%b exp=1", req_a); end
      n_checks++; if (addr_a !== 32'h100) begin n_fail++; $display("FAIL drop_addr2 got=%h exp=100", addr_a); end
      tick();
      n_checks++; if (valid_a !== 1'b0) begin n_fail++; $display("FAIL drop_valid3 got=%b exp=0", valid_a); end
   endtask

   task automatic test_redirect_hold();
      imem_ack = 1'b1; imem_rdata = 32'h1234_5678;
      tick();
      imem_ack = 1'b0; stall = 1'b1;
      n_checks++; if (pc4_a !== 32'h104) begin n_fail++; $display("FAIL hold_pc4 got=%h exp=104", pc4_a); end
      tick();
      redirect = 1'b1; redirect_pc = 32'h0000_0200;
      tick();
      redirect = 1'b0; stall = 1'b0;
      n_checks++; if (valid_a !== 1'b0) begin n_fail++; $display("FAIL rhold_valid got=%b exp=0", valid_a); end
      n_checks++; if (instr_a !== 32'h0) begin n_fail++; $display("FAIL rhold_instr got=%h exp=0", instr_a); end
      n_checks++; if (addr_a !== 32'h200) begin n_fail++; $display("FAIL rhold_addr got=%h exp=200", addr_a); end
      n_checks++; if (req_a !== 1'b1) begin n_fail++; $display("FAIL rhold_req got=%b exp=1", req_a); end
      imem_ack = 1'b1; imem_rdata = 32'hAAAA_5555; redirect = 1'b1; redirect_pc = 32'h0000_0300;
      tick();
      imem_ack = 1'b0; redirect = 1'b0;
      n_checks++; if (valid_a !== 1'b0) begin n_fail++; $display("FAIL rack_valid got=%b exp=0", valid_a); end
      n_checks++; if (addr_a !== 32'h300) begin n_fail++; $display("FAIL rack_addr got=%h exp=300", addr_a); end
      n_checks++; if (instr_a !== 32'h0) begin n_fail++; $display("FAIL rack_instr got=%h exp=0", instr_a); end
      imem_ack = 1'b1; imem_rdata = 32'h0BAD_F00D;
      tick();
      imem_ack = 1'b0;
      n_checks++; if (instr_a !== 32'h0BAD_F00D) begin n_fail++; $display("FAIL target_instr got=%h exp=0badf00d", instr_a); end
      n_checks++; if (pc4_a !== 32'h304) begin n_fail++; $display("FAIL target_pc4 got=%h exp=304", pc4_a); end
   endtask

   task automatic test_wrap_and_reset_drop();
      rst_n = 1'b0;
      repeat (2) tick();
      rst_n = 1'b1;
      tick();
      n_checks++; if (addr_b !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_addr0 got=%h exp=fffffffc", addr_b); end
      imem_ack = 1'b1; imem_rdata = 32'h1111_2222;
      tick();
      imem_ack = 1'b0;
      n_checks++; if (pc4_b !== 32'h0) begin n_fail++; $display("FAIL wrap_pc4 got=%h exp=0", pc4_b); end
      n_checks++; if (valid_b !== 1'b1) begin n_fail++; $display("FAIL wrap_valid got=%b exp=1", valid_b); end
      tick();
      n_checks++; if (addr_b !== 32'h0) begin n_fail++; $display("FAIL wrap_addr1 got=%h exp=0", addr_b); end
      n_checks++; if (req_b !== 1'b1) begin n_fail++; $display("FAIL wrap_req got=%b exp=1", req_b); end
      redirect = 1'b1; redirect_pc = 32'h0000_0040;
      tick();
      redirect = 1'b0;
      n_checks++; if (addr_a !== 32'h4) begin n_fail++; $display("FAIL rdrop_addr got=%h exp=4", addr_a); end
      rst_n = 1'b0;
      tick();
      n_checks++; if (req_a !== 1'b0) begin n_fail++; $display("FAIL rdrop_req got=%b exp=0", req_a); end
      n_checks++; if (addr_a !== 32'h0) begin n_fail++; $display("FAIL rdrop_rstaddr got=%h exp=0", addr_a); end
      rst_n = 1'b1;
   endtask

   initial begin
      test_reset();
      test_first_ack();
      test_stall();
      test_redirect_drop();
      test_redirect_hold();
      test_wrap_and_reset_drop();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
